// File: rtl/md_pkg.sv
// md_pkg: shared encodings for the multiply/divide unit.
//   - e_op operation codes (the decoder maps funct onto these same values)
//   - default latencies for the multi-cycle operations
//   - sequencer state encoding
package md_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;
  localparam logic [2:0] MD_MFHI  = 3'd6;
  localparam logic [2:0] MD_MFLO  = 3'd7;

  localparam int unsigned MD_MULT_CYCLES_DEF = 5;
  localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

  typedef enum logic [0:0] {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_t;

  // True for the ops that occupy the unit for several cycles.
  function automatic logic md_is_arith(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// md_arith: combinational multiply/divide datapath.
//   op       in   operation code (md_pkg encoding)
//   a, b     in   operands ([$rs], [$rt])
//   hi, lo   out  result halves (product, or remainder/quotient)
//   div_zero out  DIV/DIVU with a zero divisor
module md_arith
  import md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        sdiv;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] divisor;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed division runs on magnitudes and fixes the signs afterwards; this
  // also yields 0x80000000 / -1 = 0x80000000 rem 0 without a special case.
  assign sdiv     = (op == MD_DIV);
  assign mag_a    = (sdiv && a[31]) ? -a : a;
  assign mag_b    = (sdiv && b[31]) ? -b : b;
  assign div_zero = ((op == MD_DIV) || (op == MD_DIVU)) && (b == '0);
  assign divisor  = (b == '0) ? 32'd1 : mag_b;
  assign q_mag    = mag_a / divisor;
  assign r_mag    = mag_a % divisor;
  assign quot     = (sdiv && (a[31] ^ b[31])) ? -q_mag : q_mag;
  assign rem      = (sdiv && a[31]) ? -r_mag : r_mag;

  always_comb begin
    hi = '0;
    lo = '0;
    case (op)
      MD_MULT:  {hi, lo} = prod_s;
      MD_MULTU: {hi, lo} = prod_u;
      MD_DIV, MD_DIVU: begin
        hi = rem;
        lo = quot;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// md_sequencer: E-stage multiply/divide sequencer owning HI/LO.
//   clk      in   pipeline clock
//   reset    in   asynchronous active-low reset
//   e_start  in   valid muldiv instruction in E
//   e_op     in   operation code (md_pkg encoding)
//   e_rs     in   forwarded [$rs]
//   e_rt     in   forwarded [$rt]
//   d_is_md  in   D-stage instruction is a muldiv op
//   stall    out  freeze request to the hazard unit
//   busy     out  multi-cycle operation in flight
//   md_rd    out  HI for MFHI, LO for MFLO, else 0
//   hi, lo   out  architectural HI/LO
module md_sequencer
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_start,
  input  logic [2:0]  e_op,
  input  logic [31:0] e_rs,
  input  logic [31:0] e_rt,
  input  logic        d_is_md,
  output logic        stall,
  output logic        busy,
  output logic [31:0] md_rd,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_t         state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  lat;
  logic [31:0]       hi_q;
  logic [31:0]       lo_q;
  logic [31:0]       hi_tmp;
  logic [31:0]       lo_tmp;
  logic              dz_tmp;
  logic [31:0]       a_hi;
  logic [31:0]       a_lo;
  logic              a_dz;
  logic              is_arith;

  md_arith u_arith (
    .op       (e_op),
    .a        (e_rs),
    .b        (e_rt),
    .hi       (a_hi),
    .lo       (a_lo),
    .div_zero (a_dz)
  );

  assign is_arith = md_is_arith(e_op);
  assign lat      = ((e_op == MD_MULT) || (e_op == MD_MULTU)) ? CNT_W'(MULT_CYCLES)
                                                             : CNT_W'(DIV_CYCLES);
  assign busy     = (cnt != '0);
  assign stall    = d_is_md & (busy | (e_start & is_arith));
  assign hi       = hi_q;
  assign lo       = lo_q;

  always_comb begin
    md_rd = '0;
    if (e_op == MD_MFHI)      md_rd = hi_q;
    else if (e_op == MD_MFLO) md_rd = lo_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= MD_IDLE;
      cnt    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      hi_tmp <= '0;
      lo_tmp <= '0;
      dz_tmp <= 1'b0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (e_start) begin
            if (is_arith) begin
              hi_tmp <= a_hi;
              lo_tmp <= a_lo;
              dz_tmp <= a_dz;
              cnt    <= lat;
              state  <= MD_RUN;
            end else if (e_op == MD_MTHI) begin
              hi_q <= e_rs;
            end else if (e_op == MD_MTLO) begin
              lo_q <= e_rs;
            end
          end
        end
        MD_RUN: begin
          // Any e_start here is dropped; the stall logic keeps it from happening.
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= MD_IDLE;
            if (!dz_tmp) begin
              hi_q <= hi_tmp;
              lo_q <= lo_tmp;
            end
          end
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

  a_no_start_while_busy: assert property (@(posedge clk) disable iff (!reset) !(e_start && busy));

endmodule

// File: tb/tb_md_sequencer.sv
module tb_md_sequencer;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        e_start = 1'b0;
  logic [2:0]  e_op = MD_MFHI;
  logic [31:0] e_rs = '0;
  logic [31:0] e_rt = '0;
  logic        d_is_md = 1'b0;
  logic        stall;
  logic        busy;
  logic [31:0] md_rd;
  logic [31:0] hi;
  logic [31:0] lo;

  md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .e_start (e_start),
    .e_op    (e_op),
    .e_rs    (e_rs),
    .e_rt    (e_rt),
    .d_is_md (d_is_md),
    .stall   (stall),
    .busy    (busy),
    .md_rd   (md_rd),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int unsigned exp_lat;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int unsigned lat;
  } exp_t;

  vec_t        vecs[6];
  exp_t        sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Independent reference: 64-bit integer arithmetic, tracks HI/LO for divide-by-zero.
  task automatic model(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       output logic [31:0] eh, output logic [31:0] el);
    longint      a, b, p, q, r;
    logic [63:0] pu;
    eh = m_hi;
    el = m_lo;
    a = longint'($signed(rs));
    b = longint'($signed(rt));
    case (op)
      MD_MULT: begin
        p = a * b;
        {eh, el} = p;
      end
      MD_MULTU: begin
        pu = {32'd0, rs} * {32'd0, rt};
        {eh, el} = pu;
      end
      MD_DIV: if (rt != 0) begin
        q = a / b;
        r = a % b;
        el = q[31:0];
        eh = r[31:0];
      end
      MD_DIVU: if (rt != 0) begin
        el = rs / rt;
        eh = rs % rt;
      end
      default: ;
    endcase
  endtask

  task automatic run_arith(input string name, input logic [2:0] op, input logic [31:0] rs,
                           input logic [31:0] rt, input logic [31:0] eh, input logic [31:0] el,
                           input int unsigned elat);
    exp_t        e;
    int unsigned n;
    sb.push_back('{hi: eh, lo: el, lat: elat});
    @(negedge clk);
    e_op = op; e_rs = rs; e_rt = rt; e_start = 1'b1; d_is_md = 1'b0;
    @(posedge clk);
    #1 e_start = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    e = sb.pop_front();
    check({name, " busy_cycles"}, n, e.lat);
    check({name, " hi"}, hi, e.hi);
    check({name, " lo"}, lo, e.lo);
    m_hi = e.hi;
    m_lo = e.lo;
  endtask

  task automatic move_to(input string name, input logic [2:0] op, input logic [31:0] val);
    @(negedge clk);
    e_op = op; e_rs = val; e_start = 1'b1; d_is_md = 1'b1;
    #1 check({name, " no_stall"}, stall, 1'b0);
    @(posedge clk);
    #1 e_start = 1'b0;
    @(negedge clk);
    e_op = (op == MD_MTHI) ? MD_MFHI : MD_MFLO;
    d_is_md = 1'b0;
    #1 check({name, " md_rd"}, md_rd, val);
    if (op == MD_MTHI) m_hi = val; else m_lo = val;
  endtask

  initial begin
    logic [31:0] eh, el;
    logic [2:0]  rop;
    logic [31:0] rrs, rrt;
    int unsigned n;

    vecs[0] = '{MD_MULT,  32'hFFFFFFFE, 32'd3,       32'hFFFFFFFF, 32'hFFFFFFFA, 5,  "mult_neg"};
    vecs[1] = '{MD_MULTU, 32'hFFFFFFFE, 32'd3,       32'h00000002, 32'hFFFFFFFA, 5,  "multu"};
    vecs[2] = '{MD_DIV,   32'hFFFFFFF9, 32'd2,       32'hFFFFFFFF, 32'hFFFFFFFD, 10, "div_neg"};
    vecs[3] = '{MD_DIVU,  32'd7,        32'd2,       32'h00000001, 32'h00000003, 10, "divu"};
    vecs[4] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10, "div_ovf"};
    vecs[5] = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10, "div_negdiv"};

    // Reset state
    d_is_md = 1'b1;
    repeat (3) @(negedge clk);
    check("rst hi", hi, 32'd0);
    check("rst lo", lo, 32'd0);
    check("rst busy", busy, 1'b0);
    check("rst stall", stall, 1'b0);
    reset = 1'b1;
    d_is_md = 1'b0;

    foreach (vecs[i])
      run_arith(vecs[i].name, vecs[i].op, vecs[i].rs, vecs[i].rt,
                vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_lat);

    // MTHI then MFHI back-to-back, MTLO likewise
    move_to("mthi", MD_MTHI, 32'h0000ABCD);
    move_to("mtlo", MD_MTLO, 32'h00001234);

    // Divide by zero leaves HI/LO alone but still takes the full latency
    move_to("mthi11", MD_MTHI, 32'h11);
    move_to("mtlo22", MD_MTLO, 32'h22);
    run_arith("div0", MD_DIV, 32'd5, 32'd0, 32'h11, 32'h22, 10);
    run_arith("divu0", MD_DIVU, 32'hFFFF0000, 32'd0, 32'h11, 32'h22, 10);

    // MULT in E with MFLO waiting in D: stall for the E cycle plus 5 busy cycles
    model(MD_MULT, 32'd12345, 32'hFFFFFF00, eh, el);
    @(negedge clk);
    e_op = MD_MULT; e_rs = 32'd12345; e_rt = 32'hFFFFFF00; e_start = 1'b1; d_is_md = 1'b1;
    n = 0;
    #1 if (stall) n++;
    @(posedge clk);
    #1 e_start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!stall) break;
      n++;
    end
    check("mult_mflo stall_cycles", n, 6);
    e_op = MD_MFLO;
    d_is_md = 1'b0;
    #1 check("mult_mflo md_rd", md_rd, el);
    check("mult_mflo hi", hi, eh);
    m_hi = eh;
    m_lo = el;

    // Non-muldiv in D while busy must not stall
    @(negedge clk);
    e_op = MD_DIVU; e_rs = 32'd100; e_rt = 32'd9; e_start = 1'b1; d_is_md = 1'b0;
    @(posedge clk);
    #1 e_start = 1'b0;
    repeat (3) @(negedge clk);
    #1 check("nonmd busy", busy, 1'b1);
    check("nonmd stall", stall, 1'b0);
    d_is_md = 1'b1;
    #1 check("md_in_d stall", stall, 1'b1);
    d_is_md = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("nonmd lo", lo, 32'd11);
    check("nonmd hi", hi, 32'd1);
    m_hi = 32'd1;
    m_lo = 32'd11;

    // Randomised ops against the model
    for (int k = 0; k < 8; k++) begin
      rop = 3'($urandom_range(0, 3));
      rrs = $urandom;
      rrt = (k % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if (k % 2 == 0 && (rop == MD_DIV)) rrt = -rrt;
      model(rop, rrs, rrt, eh, el);
      run_arith($sformatf("rand%0d", k), rop, rrs, rrt, eh, el,
                (rop == MD_MULT || rop == MD_MULTU) ? 5 : 10);
    end

    // Reset mid-RUN: immediate clear, no commit afterwards
    move_to("pre_rst", MD_MTHI, 32'hDEAD0001);
    @(negedge clk);
    e_op = MD_DIV; e_rs = 32'd100; e_rt = 32'd7; e_start = 1'b1;
    @(posedge clk);
    #1 e_start = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    d_is_md = 1'b1;
    #1 check("midrst hi", hi, 32'd0);
    check("midrst lo", lo, 32'd0);
    check("midrst busy", busy, 1'b0);
    check("midrst stall", stall, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    d_is_md = 1'b0;
    repeat (15) @(negedge clk);
    check("postrst busy", busy, 1'b0);
    check("postrst hi", hi, 32'd0);
    check("postrst lo", lo, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
